eth_rx_frame_check: RTL and testbench

- Sits directly downstream of the MII receive assembler, which shifts 64 post-SFD bytes into a 512-bit frame buffer.
- Accepts one captured 64-byte frame per valid strobe and extracts the dst MAC, src MAC and EtherType.
- Computes IEEE 802.3 CRC-32 over bytes 0..59 and compares it against the FCS in bytes 60..63.
- Reports address-match and CRC status to the MAC control logic.

---
 rtl/eth_rx_frame_check.sv | 177 +++++++++++++++++
 tb/tb_eth_rx_frame_check.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_check.sv
// Receive-side frame checker: shadows one 64-byte frame and runs a byte-serial CRC-32 over
// bytes 0..59. It also reports address match and FCS status once per accepted frame.
module eth_rx_frame_check #(
    parameter logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          PROMISC = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [511:0] i_frame_in,
    input  logic         i_frame_vld,
    output logic         o_busy,
    output logic         o_done,
    output logic [47:0]  o_dst_mac,
    output logic [47:0]  o_src_mac,
    output logic [15:0]  o_eth_type,
    output logic         o_addr_match,
    output logic         o_crc_ok,
    output logic         o_frame_good,
    output logic [7:0]   o_drop_cnt
);

    localparam logic [31:0] CrcPoly = 32'hEDB8_8320;
    localparam logic [31:0] CrcInit = 32'hFFFF_FFFF;
    localparam logic [5:0]  LastIdx = 6'd59;

    typedef enum logic [1:0] {StIdle, StRun, StCmp} state_e;

    state_e         r_state, w_state_nxt;
    logic [511:0]   r_shadow, w_shadow_nxt;
    logic [5:0]     r_idx, w_idx_nxt;
    logic [31:0]    r_crc, w_crc_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;
    logic [47:0]    r_dst, w_dst_nxt;
    logic [47:0]    r_src, w_src_nxt;
    logic [15:0]    r_type, w_type_nxt;
    logic           r_match, w_match_nxt;
    logic           r_crc_ok, w_crc_ok_nxt;
    logic           r_good, w_good_nxt;
    logic [7:0]     r_drop, w_drop_nxt;

    logic [7:0]     w_byte;
    logic [47:0]    w_dst;
    logic [47:0]    w_src;
    logic [15:0]    w_type;
    logic           w_addr_hit;
    logic           w_fcs_ok;

    // Reflected CRC-32, bits of the byte consumed LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CrcPoly;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign w_byte = r_shadow[{r_idx, 3'b000} +: 8];

    // Header fields are big-endian on the wire: byte 0 lands in the MSB.
    always_comb begin
        w_dst = '0;
        w_src = '0;
        for (int i = 0; i < 6; i++) begin
            w_dst[47 - 8 * i -: 8] = r_shadow[8 * i +: 8];
            w_src[47 - 8 * i -: 8] = r_shadow[8 * (i + 6) +: 8];
        end
        w_type = {r_shadow[103:96], r_shadow[111:104]};
    end

    assign w_addr_hit = PROMISC || (w_dst == MY_MAC) || (w_dst == 48'hFFFF_FFFF_FFFF);
    // Bytes 63..60 in descending order already sit contiguously at the top of the frame.
    assign w_fcs_ok   = (~r_crc == r_shadow[511:480]);

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_idx_nxt    = r_idx;
        w_crc_nxt    = r_crc;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_dst_nxt    = r_dst;
        w_src_nxt    = r_src;
        w_type_nxt   = r_type;
        w_match_nxt  = r_match;
        w_crc_ok_nxt = r_crc_ok;
        w_good_nxt   = r_good;
        unique case (r_state)
            StIdle: begin
                if (i_frame_vld) begin
                    w_shadow_nxt = i_frame_in;
                    w_idx_nxt    = '0;
                    w_crc_nxt    = CrcInit;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = StRun;
                end
            end
            StRun: begin
                w_crc_nxt = crc_byte(r_crc, w_byte);
                w_idx_nxt = r_idx + 6'd1;
                if (r_idx == LastIdx) begin
                    w_state_nxt = StCmp;
                end
            end
            StCmp: begin
                w_dst_nxt    = w_dst;
                w_src_nxt    = w_src;
                w_type_nxt   = w_type;
                w_match_nxt  = w_addr_hit;
                w_crc_ok_nxt = w_fcs_ok;
                w_good_nxt   = w_fcs_ok & w_addr_hit;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_drop_nxt = r_drop;
        if (i_frame_vld && r_busy && (r_drop != 8'hFF)) begin
            w_drop_nxt = r_drop + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_shadow <= '0;
            r_idx    <= '0;
            r_crc    <= CrcInit;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dst    <= '0;
            r_src    <= '0;
            r_type   <= '0;
            r_match  <= 1'b0;
            r_crc_ok <= 1'b0;
            r_good   <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_idx    <= w_idx_nxt;
            r_crc    <= w_crc_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_dst    <= w_dst_nxt;
            r_src    <= w_src_nxt;
            r_type   <= w_type_nxt;
            r_match  <= w_match_nxt;
            r_crc_ok <= w_crc_ok_nxt;
            r_good   <= w_good_nxt;
            r_drop   <= w_drop_nxt;
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_dst_mac    = r_dst;
    assign o_src_mac    = r_src;
    assign o_eth_type   = r_type;
    assign o_addr_match = r_match;
    assign o_crc_ok     = r_crc_ok;
    assign o_frame_good = r_good;
    assign o_drop_cnt   = r_drop;

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Bench for eth_rx_frame_check: directed and random frames checked against a table-driven
// CRC/field model. A second instance runs with PROMISC=1.
module tb_eth_rx_frame_check;

    localparam logic [47:0] MY    = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    typedef logic [7:0] byte_q_t[$];

    logic         clk = 1'b0;
    logic         rst;
    logic         vld;
    logic [511:0] fin;

    logic         busy, done, am, ok, good;
    logic [47:0]  dst, src;
    logic [15:0]  typ;
    logic [7:0]   drops;
    logic         p_busy, p_done, p_am, p_ok, p_good;
    logic [47:0]  p_dst, p_src;
    logic [15:0]  p_typ;
    logic [7:0]   p_drops;

    int           n_asserts = 0;
    int           n_fail    = 0;
    int           exp_drops = 0;
    logic [7:0]   fb [64];
    logic [31:0]  crc_tbl [256];

    eth_rx_frame_check #(.MY_MAC(MY), .PROMISC(1'b0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_frame_in(fin), .i_frame_vld(vld),
        .o_busy(busy), .o_done(done), .o_dst_mac(dst), .o_src_mac(src),
        .o_eth_type(typ), .o_addr_match(am), .o_crc_ok(ok), .o_frame_good(good),
        .o_drop_cnt(drops)
    );

    eth_rx_frame_check #(.MY_MAC(MY), .PROMISC(1'b1)) u_prom (
        .i_clk(clk), .i_rst(rst), .i_frame_in(fin), .i_frame_vld(vld),
        .o_busy(p_busy), .o_done(p_done), .o_dst_mac(p_dst), .o_src_mac(p_src),
        .o_eth_type(p_typ), .o_addr_match(p_am), .o_crc_ok(p_ok), .o_frame_good(p_good),
        .o_drop_cnt(p_drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_q(input byte_q_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) c = crc_tbl[(c[7:0] ^ q[i])] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic logic [31:0] frame_crc();
        byte_q_t q;
        for (int i = 0; i < 60; i++) q.push_back(fb[i]);
        return crc_q(q);
    endfunction

    function automatic logic [511:0] pack();
        logic [511:0] f;
        for (int i = 0; i < 64; i++) f[8 * i +: 8] = fb[i];
        return f;
    endfunction

    task automatic build(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                         input bit rnd);
        logic [31:0] c;
        for (int i = 0; i < 6; i++) begin
            fb[i]     = d[47 - 8 * i -: 8];
            fb[6 + i] = s[47 - 8 * i -: 8];
        end
        fb[12] = t[15:8];
        fb[13] = t[7:0];
        for (int i = 14; i < 60; i++) fb[i] = rnd ? 8'($urandom) : 8'(i);
        c = frame_crc();
        fb[60] = c[7:0];
        fb[61] = c[15:8];
        fb[62] = c[23:16];
        fb[63] = c[31:24];
    endtask

    // Sends the frame currently in fb and checks every result against the model.
    task automatic run_frame(input string tag);
        logic [47:0] ed, es;
        logic [15:0] et;
        logic        eok, eam;
        int          cnt;
        for (int i = 0; i < 6; i++) begin
            ed[47 - 8 * i -: 8] = fb[i];
            es[47 - 8 * i -: 8] = fb[6 + i];
        end
        et  = {fb[12], fb[13]};
        eok = (frame_crc() == {fb[63], fb[62], fb[61], fb[60]});
        eam = (ed == MY) || (ed == BCAST);
        @(negedge clk);
        fin = pack();
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        fin = {16{$urandom}};
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        cnt = 0;
        while (done !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'd61);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_dst"}, 64'(dst), 64'(ed));
        chk({tag, "_src"}, 64'(src), 64'(es));
        chk({tag, "_type"}, 64'(typ), 64'(et));
        chk({tag, "_addr"}, 64'(am), 64'(eam));
        chk({tag, "_crc"}, 64'(ok), 64'(eok));
        chk({tag, "_good"}, 64'(good), 64'(eok & eam));
        chk({tag, "_p_addr"}, 64'(p_am), 64'd1);
        chk({tag, "_p_good"}, 64'(p_good), 64'(eok));
        chk({tag, "_drops"}, 64'(drops), 64'(exp_drops));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        byte_q_t     q;
        logic [31:0] r;
        int          cnt, ndone, bit_pos;
        logic [47:0] rd;

        for (int n = 0; n < 256; n++) begin
            r = 32'(n);
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
            crc_tbl[n] = r;
        end
        for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
        chk("crc_check_value", 64'(crc_q(q)), 64'hCBF4_3926);

        rst = 1'b1;
        vld = 1'b0;
        fin = {16{$urandom}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fields", {dst[31:0], src[15:0], typ}, 64'd0);
        chk("rst_flags", {am, ok, good, drops}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        build(MY, 48'h00_11_22_33_44_55, 16'h0800, 1'b0);
        run_frame("good");

        fb[30] = fb[30] ^ 8'h01;
        run_frame("bitflip");

        build(BCAST, 48'h00_11_22_33_44_55, 16'h0806, 1'b0);
        run_frame("bcast");

        build(48'h02_00_00_00_00_02, 48'h00_11_22_33_44_55, 16'h86DD, 1'b0);
        run_frame("other");

        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: rd = MY;
                1: rd = BCAST;
                2: rd = {$urandom, 16'($urandom)};
                default: rd = MY ^ (48'd1 << $urandom_range(0, 47));
            endcase
            build(rd, {$urandom, 16'($urandom)}, 16'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                bit_pos = $urandom_range(0, 511);
                fb[bit_pos / 8][bit_pos % 8] = ~fb[bit_pos / 8][bit_pos % 8];
            end
            run_frame("random");
        end

        // Drops at T+10 and at the compare edge T+61, then an accept at T+62.
        build(MY, 48'h00_11_22_33_44_55, 16'h0800, 1'b0);
        @(negedge clk);
        fin = pack();
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        chk("drop_t10_done", 64'(done), 64'd0);
        chk("drop_t10_busy", 64'(busy), 64'd1);
        repeat (50) @(posedge clk);
        #1;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        chk("drop_t61_done", 64'(done), 64'd1);
        chk("drop_t61_crc", 64'(good), 64'd1);
        chk("drop_cnt_2", 64'(drops), 64'd2);
        exp_drops = 2;
        fin = pack();
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        chk("accept_t62_busy", 64'(busy), 64'd1);
        chk("accept_t62_done", 64'(done), 64'd0);
        cnt = 0;
        while (done !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("accept_t123", 64'(cnt), 64'd61);
        chk("accept_drops", 64'(drops), 64'd2);
        @(posedge clk);
        #1;

        // Reset in the middle of RUN aborts the frame and clears everything.
        build(MY, 48'h00_11_22_33_44_55, 16'h0800, 1'b1);
        @(negedge clk);
        fin = pack();
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_drops = 0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_fields", {dst[31:0], src[15:0], typ}, 64'd0);
        chk("abort_flags", {done, am, ok, good, drops}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_frame("after_rst");

        // Continuous strobe: many more than 255 drops, counter must saturate.
        @(negedge clk);
        fin = pack();
        vld = 1'b1;
        repeat (330) @(posedge clk);
        #1;
        vld = 1'b0;
        chk("drop_saturate", 64'(drops), 64'd255);
        exp_drops = 255;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("drain_idle", 64'(busy), 64'd0);
        build(BCAST, 48'h00_AA_BB_CC_DD_EE, 16'h0800, 1'b1);
        run_frame("post_sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
